fc2_seq_ctrl: RTL and testbench
===============================

// Module: fc2_seq_ctrl
// PURPOSE
// - Sequencer for the structure1 FC2 MAC datapath.
// - Walks the loop nest species -> output neuron -> input feature.
// - Drives weight/feature/bias BRAM reads plus accumulator and result-write strobes.
// - Replaces free-running address/cnt logic and derived-clock (out_en edge) strobes with one single-clock FSM.
// - Sits between the layer-level start/done handshake and the FC2 MAC + result RAM.
// PARAMETERS
// - SPECIES   42  number of input channel groups (outer loop)
// - FC1_NUM   64  input features per neuron (inner loop)
// - FC2_NUM    2  output neurons per species (middle loop)
// - AW_W      18  weight address width
// - AW_D      15  feature address width
// - AW_O      14  result address width
// PORTS
// - clk        in   1     single clock; all logic on posedge
// - rst_n      in   1     synchronous active-low reset
// - start      in   1     begin a layer pass; sampled in IDLE only
// - hold       in   1     backpressure; freezes issue while high
// - busy       out  1     high from the cycle after start is accepted until done
// - w_en       out  1     weight + feature BRAM read enable (one issue)
// - w_addr     out  AW_W  neuron*FC1_NUM + k
// - d_addr     out  AW_D  species*FC1_NUM + k
// - bias_rd    out  1     bias read, issued with k==0
// - bias_addr  out  8     current neuron index
// - acc_en     out  1     accumulate product (w_en delayed 1 cycle, BRAM latency 1)
// - acc_first  out  1     with acc_en: load product instead of add (k==0)
// - acc_last   out  1     with acc_en: final term of neuron (k==FC1_NUM-1)
// - res_vld    out  1     one-cycle strobe; accumulator+bias is final, write result
// - res_addr   out  AW_O  species*FC2_NUM + neuron, valid with res_vld
// - done       out  1     one-cycle pulse; pass complete
// BEHAVIOUR
// - Reset: every output is 0 and the FSM is in IDLE. Reset mid-pass aborts immediately; no res_vld or done follows.
// - FSM states:
//   - IDLE: start=1 -> RUN, counters cleared.
//   - RUN: one issue per cycle when hold=0. The final issue (s=SPECIES-1, n=FC2_NUM-1, k=FC1_NUM-1) -> DRAIN.
//   - DRAIN: waits for the pipeline to empty, then -> DONE.
//   - DONE: done=1 for one cycle -> IDLE.
// - Counters: k wraps at FC1_NUM-1 and carries n; n wraps at FC2_NUM-1 and carries s. All are registered; addresses are combinational from them.
// - Issue timing: start sampled at edge E0 -> w_en=1 in cycle E0+1 with address (0,0,0).
// - Hold: while hold=1, w_en=0 and counters freeze. Already-issued terms still advance through acc_en/res_vld; hold gates issue only.
// - Pipeline:
//   - acc_en, acc_first, acc_last are registered copies of issue-stage w_en and the k==0 / k==FC1_NUM-1 flags.
//   - res_vld = registered(acc_en & acc_last).
//   - res_addr is captured from the issue-stage s,n and pipelined alongside.
// - done asserts the cycle after the last res_vld; busy falls in that same cycle.
// - start while busy is ignored. start held high in DONE is not seen until IDLE.
// - Simultaneous hold=1 on the final issue cycle: the final issue is deferred; there is no early DRAIN.
// - Total issues = SPECIES*FC2_NUM*FC1_NUM (5376 at defaults). res_vld count = SPECIES*FC2_NUM (84).
// - Address arithmetic is unsigned. Widths are sized so the maximum index never overflows; elaboration fails if AW_* is too small.
// STRUCTURE
// - fc2_pkg: state enum (IDLE, RUN, DRAIN, DONE), default loop-bound localparams, $clog2-derived counter widths.
// - One sub-module, fc2_nest_cnt: a 3-level wrap/carry counter with enable, providing first/last flags per level. Instantiated once.
// - Top level holds the FSM, the 2-stage strobe pipeline, and address generation.
// TESTING (SPECIES=2, FC1_NUM=4, FC2_NUM=2 unless noted)
// - Basic pass: start pulse at E0, hold=0
//   -> w_en high cycles 1..16
//   -> acc_en 2..17
//   -> res_vld at 6,10,14,18 with res_addr 0,1,2,3
//   -> done at 19, busy 1..18.
// - Address check: cycle 5 -> w_addr=4, d_addr=0, bias_rd=1, bias_addr=1.
//   Cycle 9 -> w_addr=0, d_addr=4.
// - Hold: hold=1 cycles 3..5
//   -> no w_en in 3..5, w_addr resumes at 2 in cycle 6
//   -> final res_vld at 21, done at 22.
// - Reset mid-pass: rst_n=0 at cycle 8 -> all outputs 0 next cycle, no further res_vld; a new start runs a clean full pass.
// - start re-asserted at cycles 3 and 19 -> ignored; a start at 20 (IDLE) begins a second identical pass.
// - Defaults: 5376 w_en cycles, 84 res_vld, last res_addr=83, done exactly once.

Source files
------------

// File: rtl/fc2_pkg.sv
// Shared types and defaults for the FC2 sequencer: FSM state encoding,
// default loop bounds and address widths, and a counter-width helper.
package fc2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc2_state_t;

  localparam int DEF_SPECIES = 42;
  localparam int DEF_FC1_NUM = 64;
  localparam int DEF_FC2_NUM = 2;
  localparam int DEF_AW_W    = 18;
  localparam int DEF_AW_D    = 15;
  localparam int DEF_AW_O    = 14;

  // Bits needed to hold 0..n-1; a bound of 1 still gets a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc2_nest_cnt.sv
// Three-level wrap/carry counter: k (inner) carries n, n carries s.
// Advances only when en is high; clr zeroes all levels.
module fc2_nest_cnt
  import fc2_pkg::*;
#(
  parameter int N_K = DEF_FC1_NUM,
  parameter int N_N = DEF_FC2_NUM,
  parameter int N_S = DEF_SPECIES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [cnt_w(N_K)-1:0] k,
  output logic [cnt_w(N_N)-1:0] n,
  output logic [cnt_w(N_S)-1:0] s,
  output logic                  k_first,
  output logic                  k_last,
  output logic                  n_last,
  output logic                  s_last
);

  localparam int KW = cnt_w(N_K);
  localparam int NW = cnt_w(N_N);
  localparam int SW = cnt_w(N_S);

  logic [KW-1:0] k_reg;
  logic [NW-1:0] n_reg;
  logic [SW-1:0] s_reg;

  // Level flags decoded straight from the registered counts
  always_comb begin
    k_first = (k_reg == '0);
    k_last  = (k_reg == KW'(N_K - 1));
    n_last  = (n_reg == NW'(N_N - 1));
    s_last  = (s_reg == SW'(N_S - 1));
  end

  // Ripple carry: inner level wraps into the next one only on its last value
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      k_reg <= '0;
      n_reg <= '0;
      s_reg <= '0;
    end else if (en) begin
      if (k_last) begin
        k_reg <= '0;
        if (n_last) begin
          n_reg <= '0;
          s_reg <= s_last ? '0 : s_reg + SW'(1);
        end else begin
          n_reg <= n_reg + NW'(1);
        end
      end else begin
        k_reg <= k_reg + KW'(1);
      end
    end
  end

  assign k = k_reg;
  assign n = n_reg;
  assign s = s_reg;

endmodule

// File: rtl/fc2_seq_ctrl.sv
// FC2 MAC sequencer: walks species -> neuron -> feature, issues BRAM reads,
// and pipelines accumulate / result-write strobes behind the 1-cycle BRAM.
module fc2_seq_ctrl
  import fc2_pkg::*;
#(
  parameter int SPECIES = DEF_SPECIES,
  parameter int FC1_NUM = DEF_FC1_NUM,
  parameter int FC2_NUM = DEF_FC2_NUM,
  parameter int AW_W    = DEF_AW_W,
  parameter int AW_D    = DEF_AW_D,
  parameter int AW_O    = DEF_AW_O
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            w_en,
  output logic [AW_W-1:0] w_addr,
  output logic [AW_D-1:0] d_addr,
  output logic            bias_rd,
  output logic [7:0]      bias_addr,
  output logic            acc_en,
  output logic            acc_first,
  output logic            acc_last,
  output logic            res_vld,
  output logic [AW_O-1:0] res_addr,
  output logic            done
);

  // Refuse to elaborate when an address port cannot hold its largest index
  if (longint'(FC2_NUM) * FC1_NUM > (longint'(1) << AW_W)) begin : g_bad_aw_w
    $error("fc2_seq_ctrl: AW_W too small for FC2_NUM*FC1_NUM");
  end
  if (longint'(SPECIES) * FC1_NUM > (longint'(1) << AW_D)) begin : g_bad_aw_d
    $error("fc2_seq_ctrl: AW_D too small for SPECIES*FC1_NUM");
  end
  if (longint'(SPECIES) * FC2_NUM > (longint'(1) << AW_O)) begin : g_bad_aw_o
    $error("fc2_seq_ctrl: AW_O too small for SPECIES*FC2_NUM");
  end
  if (FC2_NUM > 256) begin : g_bad_bias
    $error("fc2_seq_ctrl: FC2_NUM exceeds 8-bit bias address");
  end

  localparam int KW = cnt_w(FC1_NUM);
  localparam int NW = cnt_w(FC2_NUM);
  localparam int SW = cnt_w(SPECIES);

  fc2_state_t state_reg, state_next;

  logic [KW-1:0]   k_cnt;
  logic [NW-1:0]   n_cnt;
  logic [SW-1:0]   s_cnt;
  logic            k_first, k_last, n_last, s_last;
  logic            final_issue;
  logic [AW_O-1:0] issue_raddr;

  logic            acc_en_reg, acc_first_reg, acc_last_reg;
  logic            res_vld_reg;
  logic [AW_O-1:0] raddr1_reg, res_addr_reg;

  // Counters are held clear in IDLE so every pass starts at (0,0,0)
  fc2_nest_cnt #(
    .N_K (FC1_NUM),
    .N_N (FC2_NUM),
    .N_S (SPECIES)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_reg == IDLE),
    .en      (w_en),
    .k       (k_cnt),
    .n       (n_cnt),
    .s       (s_cnt),
    .k_first (k_first),
    .k_last  (k_last),
    .n_last  (n_last),
    .s_last  (s_last)
  );

  assign final_issue = k_last & n_last & s_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state: DRAIN leaves once the accumulate stage is empty, so the last
  // res_vld is on the output in the same cycle and done follows it
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (!hold && final_issue) state_next = DRAIN;
      DRAIN:   if (!acc_en_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: hold gates issue only, never the strobes already in flight
  always_comb begin
    busy = (state_reg == RUN) || (state_reg == DRAIN);
    done = (state_reg == DONE);
    w_en = (state_reg == RUN) && !hold;
  end

  // Addresses are pure functions of the registered loop counters
  always_comb begin
    w_addr      = AW_W'(n_cnt) * AW_W'(FC1_NUM) + AW_W'(k_cnt);
    d_addr      = AW_D'(s_cnt) * AW_D'(FC1_NUM) + AW_D'(k_cnt);
    bias_addr   = 8'(n_cnt);
    bias_rd     = w_en & k_first;
    issue_raddr = AW_O'(s_cnt) * AW_O'(FC2_NUM) + AW_O'(n_cnt);
  end

  // Two-stage strobe pipeline; the result address rides along with the issue
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_en_reg    <= 1'b0;
      acc_first_reg <= 1'b0;
      acc_last_reg  <= 1'b0;
      res_vld_reg   <= 1'b0;
      raddr1_reg    <= '0;
      res_addr_reg  <= '0;
    end else begin
      acc_en_reg    <= w_en;
      acc_first_reg <= w_en & k_first;
      acc_last_reg  <= w_en & k_last;
      res_vld_reg   <= acc_en_reg & acc_last_reg;
      if (w_en) raddr1_reg <= issue_raddr;
      if (acc_en_reg && acc_last_reg) res_addr_reg <= raddr1_reg;
    end
  end

  assign acc_en    = acc_en_reg;
  assign acc_first = acc_first_reg;
  assign acc_last  = acc_last_reg;
  assign res_vld   = res_vld_reg;
  assign res_addr  = res_addr_reg;

endmodule

// File: tb/tb_fc2_seq_ctrl.sv
// Bench for fc2_seq_ctrl: a small instance (2 species, 4 features, 2 neurons)
// checked cycle by cycle against an issue-index reference model, plus a
// default-sized instance checked on whole-pass totals.
module tb_fc2_seq_ctrl;

  localparam int SP = 2, F1 = 4, F2 = 2;
  localparam int TOTAL = SP * F1 * F2;
  localparam int RES_TOTAL = SP * F2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, hold = 1'b0;
  logic busy, w_en, bias_rd, acc_en, acc_first, acc_last, res_vld, done;
  logic [17:0] w_addr;
  logic [14:0] d_addr;
  logic [7:0]  bias_addr;
  logic [13:0] res_addr;

  logic start_d = 1'b0, hold_d = 1'b0;
  logic busy_d, w_en_d, bias_rd_d, acc_en_d, acc_first_d, acc_last_d, res_vld_d, done_d;
  logic [17:0] w_addr_d;
  logic [14:0] d_addr_d;
  logic [7:0]  bias_addr_d;
  logic [13:0] res_addr_d;

  int n_cmp = 0, n_bad = 0;

  logic        obs_wen [0:255];
  logic        obs_acc [0:255];
  logic        obs_res [0:255];
  logic        obs_busy[0:255];
  logic        obs_done[0:255];
  logic        obs_brd [0:255];
  logic [17:0] obs_waddr[0:255];
  logic [14:0] obs_daddr[0:255];
  logic [7:0]  obs_baddr[0:255];
  logic [13:0] obs_raddr[0:255];

  always #5 clk = ~clk;

  fc2_seq_ctrl #(.SPECIES(SP), .FC1_NUM(F1), .FC2_NUM(F2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .busy(busy),
    .w_en(w_en), .w_addr(w_addr), .d_addr(d_addr), .bias_rd(bias_rd),
    .bias_addr(bias_addr), .acc_en(acc_en), .acc_first(acc_first),
    .acc_last(acc_last), .res_vld(res_vld), .res_addr(res_addr), .done(done)
  );

  fc2_seq_ctrl dut_def (
    .clk(clk), .rst_n(rst_n), .start(start_d), .hold(hold_d), .busy(busy_d),
    .w_en(w_en_d), .w_addr(w_addr_d), .d_addr(d_addr_d), .bias_rd(bias_rd_d),
    .bias_addr(bias_addr_d), .acc_en(acc_en_d), .acc_first(acc_first_d),
    .acc_last(acc_last_d), .res_vld(res_vld_d), .res_addr(res_addr_d), .done(done_d)
  );

  // One pass on the small DUT. Cycle 0 presents start; cycle c is the cycle
  // after edge c-1. The model tracks how many terms were issued and derives
  // every expected address from that index with plain div/mod arithmetic.
  // hold_mode: 0 none, 1 cycles 3..5, 2 random, 3 hold twice on final issue.
  task automatic run_pass(input int hold_mode, input int s1, input int s2,
                          input int rst_at, output int end_cyc);
    int issued, res_cnt, hcnt, k, n, s, p1_raddr, p2_addr;
    bit m_busy, m_run, m_done, nxt_done, hnow, done_flag;
    bit p1_en, p1_first, p1_last, p2_vld;
    logic [7:0] exp_v, got_v;
    for (int i = 0; i < 256; i++) begin
      obs_wen[i] = 0; obs_acc[i] = 0; obs_res[i] = 0; obs_busy[i] = 0;
      obs_done[i] = 0; obs_brd[i] = 0;
    end
    end_cyc = -1;
    @(negedge clk); start = 1'b1; hold = 1'b0; #1;
    n_cmp++;
    if ({busy, w_en, done, res_vld} !== 4'b0000) begin
      n_bad++;
      $display("FAIL idle_before_start: got busy/w_en/done/res_vld=%b need 0000",
               {busy, w_en, done, res_vld});
    end
    issued = 0; res_cnt = 0; hcnt = 0; p1_raddr = 0; p2_addr = 0;
    m_busy = 1; m_run = 1; m_done = 0;
    p1_en = 0; p1_first = 0; p1_last = 0; p2_vld = 0;
    done_flag = 0;
    for (int c = 1; c < 256 && !done_flag; c++) begin
      @(negedge clk);
      start = (c == s1) || (c == s2);
      case (hold_mode)
        1:       hnow = (c >= 3) && (c <= 5);
        2:       hnow = ($urandom_range(0, 3) == 0);
        3:       hnow = m_run && (issued == TOTAL - 1) && (hcnt < 2);
        default: hnow = 0;
      endcase
      if (hold_mode == 3 && hnow) hcnt++;
      hold = hnow;
      if (c == rst_at) rst_n = 1'b0;
      #1;
      k = issued % F1; n = (issued / F1) % F2; s = issued / (F1 * F2);
      exp_v = {m_busy, m_done, m_run && !hnow, m_run && !hnow && k == 0,
               p1_en, p1_first, p1_last, p2_vld};
      got_v = {busy, done, w_en, bias_rd, acc_en, acc_first, acc_last, res_vld};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL strobes cycle %0d: got busy,done,w_en,bias_rd,acc_en,acc_first,acc_last,res_vld=%b need %b",
                 c, got_v, exp_v);
      end
      if (m_run && !hnow) begin
        n_cmp++;
        if ({w_addr, d_addr, bias_addr} !== {18'(n * F1 + k), 15'(s * F1 + k), 8'(n)}) begin
          n_bad++;
          $display("FAIL issue_addr cycle %0d: got w=%0d d=%0d b=%0d need w=%0d d=%0d b=%0d",
                   c, w_addr, d_addr, bias_addr, n * F1 + k, s * F1 + k, n);
        end
      end
      if (p2_vld) begin
        n_cmp++;
        if (res_addr !== 14'(p2_addr)) begin
          n_bad++;
          $display("FAIL res_addr cycle %0d: got %0d need %0d", c, res_addr, p2_addr);
        end
      end
      obs_wen[c] = w_en; obs_acc[c] = acc_en; obs_res[c] = res_vld; obs_busy[c] = busy;
      obs_done[c] = done; obs_brd[c] = bias_rd; obs_waddr[c] = w_addr;
      obs_daddr[c] = d_addr; obs_baddr[c] = bias_addr; obs_raddr[c] = res_addr;
      if (c == rst_at || m_done) begin
        end_cyc = c; done_flag = 1;
      end else begin
        if (p2_vld) res_cnt++;
        nxt_done = p2_vld && (res_cnt == RES_TOTAL);
        if (p1_en && p1_last) p2_addr = p1_raddr;
        p2_vld = p1_en && p1_last;
        p1_en = m_run && !hnow;
        p1_first = p1_en && (k == 0);
        p1_last = p1_en && (k == F1 - 1);
        if (p1_en) p1_raddr = s * F2 + n;
        if (p1_en) issued++;
        if (issued == TOTAL) m_run = 0;
        m_done = nxt_done;
        if (nxt_done) m_busy = 0;
      end
    end
    start = 1'b0; hold = 1'b0;
    if (end_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL pass_bound: got no end of pass within 255 cycles need done");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, w_en, bias_rd, acc_en, acc_first, acc_last, res_vld, done, res_addr,
         w_addr, d_addr, bias_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_small: got strobes=%b res_addr=%0d w=%0d d=%0d need all 0",
               {busy, w_en, bias_rd, acc_en, acc_first, acc_last, res_vld, done},
               res_addr, w_addr, d_addr);
    end
    n_cmp++;
    if ({busy_d, w_en_d, bias_rd_d, acc_en_d, acc_first_d, acc_last_d, res_vld_d,
         done_d, res_addr_d, w_addr_d, d_addr_d, bias_addr_d} !== '0) begin
      n_bad++;
      $display("FAIL reset_default: got nonzero outputs need all 0");
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int e, fw, lw, fa, la, rc;
    run_pass(0, -1, -1, 0, e);
    fw = -1; lw = -1; fa = -1; la = -1; rc = 0;
    for (int i = 0; i < 256; i++) begin
      if (obs_wen[i]) begin if (fw < 0) fw = i; lw = i; end
      if (obs_acc[i]) begin if (fa < 0) fa = i; la = i; end
      if (obs_res[i]) rc++;
    end
    n_cmp++;
    if (fw != 1 || lw != 16) begin
      n_bad++; $display("FAIL basic_wen_span: got %0d..%0d need 1..16", fw, lw);
    end
    n_cmp++;
    if (fa != 2 || la != 17) begin
      n_bad++; $display("FAIL basic_acc_span: got %0d..%0d need 2..17", fa, la);
    end
    n_cmp++;
    if (rc != 4 || !obs_res[6] || !obs_res[10] || !obs_res[14] || !obs_res[18]) begin
      n_bad++; $display("FAIL basic_res_cycles: got count %0d need 4 at 6,10,14,18", rc);
    end
    n_cmp++;
    if ({obs_raddr[6], obs_raddr[10], obs_raddr[14], obs_raddr[18]} !==
        {14'd0, 14'd1, 14'd2, 14'd3}) begin
      n_bad++; $display("FAIL basic_res_addr: got %0d,%0d,%0d,%0d need 0,1,2,3",
                        obs_raddr[6], obs_raddr[10], obs_raddr[14], obs_raddr[18]);
    end
    n_cmp++;
    if (e != 19 || !obs_done[19] || !obs_busy[1] || !obs_busy[18] || obs_busy[19]) begin
      n_bad++; $display("FAIL basic_done_busy: got done cycle %0d busy18=%b busy19=%b need 19,1,0",
                        e, obs_busy[18], obs_busy[19]);
    end
    n_cmp++;
    if (obs_waddr[5] !== 18'd4 || obs_daddr[5] !== 15'd0 || obs_brd[5] !== 1'b1 ||
        obs_baddr[5] !== 8'd1) begin
      n_bad++; $display("FAIL addr_cycle5: got w=%0d d=%0d brd=%b b=%0d need 4,0,1,1",
                        obs_waddr[5], obs_daddr[5], obs_brd[5], obs_baddr[5]);
    end
    n_cmp++;
    if (obs_waddr[9] !== 18'd0 || obs_daddr[9] !== 15'd4) begin
      n_bad++; $display("FAIL addr_cycle9: got w=%0d d=%0d need 0,4", obs_waddr[9], obs_daddr[9]);
    end
  endtask

  task automatic test_hold();
    int e, lr;
    run_pass(1, -1, -1, 0, e);
    lr = -1;
    for (int i = 0; i < 256; i++) if (obs_res[i]) lr = i;
    n_cmp++;
    if (obs_wen[3] || obs_wen[4] || obs_wen[5] || !obs_wen[6] || obs_waddr[6] !== 18'd2) begin
      n_bad++; $display("FAIL hold_resume: got wen3..6=%b%b%b%b w_addr6=%0d need 0001,2",
                        obs_wen[3], obs_wen[4], obs_wen[5], obs_wen[6], obs_waddr[6]);
    end
    n_cmp++;
    if (lr != 21 || e != 22) begin
      n_bad++; $display("FAIL hold_end: got last res %0d done %0d need 21,22", lr, e);
    end
  endtask

  task automatic test_reset_mid();
    int e, bad_cyc;
    run_pass(0, -1, -1, 8, e);
    @(negedge clk); #1;
    n_cmp++;
    if ({busy, w_en, bias_rd, acc_en, acc_first, acc_last, res_vld, done, res_addr,
         w_addr, d_addr, bias_addr} !== '0) begin
      n_bad++; $display("FAIL reset_mid_clear: got strobes=%b need all 0",
                        {busy, w_en, bias_rd, acc_en, acc_first, acc_last, res_vld, done});
    end
    rst_n = 1'b1;
    bad_cyc = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (res_vld || done || busy || w_en) bad_cyc++;
    end
    n_cmp++;
    if (bad_cyc != 0) begin
      n_bad++; $display("FAIL reset_mid_quiet: got %0d active cycles need 0", bad_cyc);
    end
    run_pass(0, -1, -1, 0, e);
    n_cmp++;
    if (e != 19) begin
      n_bad++; $display("FAIL reset_mid_rerun: got done cycle %0d need 19", e);
    end
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    run_pass(0, 3, 19, 0, e1);
    run_pass(0, -1, -1, 0, e2);
    n_cmp++;
    if (e1 != 19 || e2 != 19 || obs_raddr[18] !== 14'd3 || !obs_res[18]) begin
      n_bad++; $display("FAIL back_to_back: got done %0d,%0d last res_addr %0d need 19,19,3",
                        e1, e2, obs_raddr[18]);
    end
  endtask

  task automatic test_random_hold();
    int e;
    for (int r = 0; r < 6; r++) run_pass((r == 2) ? 3 : 2, -1, -1, 0, e);
    run_pass(3, -1, -1, 0, e);
    n_cmp++;
    if (e != 21) begin
      n_bad++; $display("FAIL hold_final_issue: got done cycle %0d need 21", e);
    end
  endtask

  task automatic test_defaults();
    int wcnt, rcnt, dcnt, last_ra, first_w, cyc, tail;
    wcnt = 0; rcnt = 0; dcnt = 0; last_ra = -1; first_w = -1; cyc = 0; tail = -1;
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    while (cyc < 7000 && tail != 0) begin
      cyc++;
      #1;
      if (w_en_d) begin wcnt++; if (first_w < 0) first_w = cyc; end
      if (res_vld_d) begin rcnt++; last_ra = int'(res_addr_d); end
      if (done_d) begin dcnt++; if (tail < 0) tail = 5; end
      if (tail > 0) tail--;
      @(negedge clk);
    end
    n_cmp++;
    if (wcnt != 5376 || first_w != 1) begin
      n_bad++; $display("FAIL default_issues: got %0d first at %0d need 5376 at 1", wcnt, first_w);
    end
    n_cmp++;
    if (rcnt != 84 || last_ra != 83) begin
      n_bad++; $display("FAIL default_results: got %0d last addr %0d need 84, 83", rcnt, last_ra);
    end
    n_cmp++;
    if (dcnt != 1 || busy_d !== 1'b0) begin
      n_bad++; $display("FAIL default_done: got done count %0d busy %b need 1,0", dcnt, busy_d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random_hold();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
